// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles MSB-first bytes into instruction words,
// writes them to instruction memory, and releases the core once the XOR checksum matches.
module boot_loader #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               load_req,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_nReset,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready is
    // registered and held high for the whole of COUNT, DATA and CHECK, so the loader never stalls.
    localparam int                BPW       = INSTR_W / 8;
    localparam logic [7:0]        LAST_BYTE = 8'(BPW - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         count;
    logic [7:0]         csum;
    logic [7:0]         byte_idx;
    logic [7:0]         word_cnt;
    logic [INSTR_W-1:0] word_reg;
    logic [INSTR_W+7:0] shifted;
    logic               accept;

    assign accept    = in_valid && in_ready;
    assign shifted   = {word_reg, in_data};
    assign dbg_state = state;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_nReset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            csum       <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            word_reg   <= '0;
        end else begin
            mem_we <= 1'b0;
            // The address advances in the cycle after each write pulse.
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_ONE;
            end

            case (state)
                IDLE: begin
                    if (load_req) begin
                        state      <= COUNT;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_nReset <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        count    <= in_data;
                        csum     <= in_data;
                        byte_idx <= '0;
                        word_cnt <= '0;
                        word_reg <= '0;
                        state    <= (in_data == 8'd0) ? CHECK : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ in_data;
                        word_reg <= shifted[INSTR_W-1:0];
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx  <= '0;
                            mem_we    <= 1'b1;
                            mem_wdata <= shifted[INSTR_W-1:0];
                            word_cnt  <= word_cnt + 8'd1;
                            if (word_cnt == count - 8'd1) begin
                                state <= CHECK;
                            end
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state      <= RUN;
                            done       <= 1'b1;
                            cpu_nReset <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                RUN, ERROR: begin
                    // Reload: memory contents from the previous image are simply overwritten.
                    if (load_req) begin
                        state      <= COUNT;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_nReset <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: scenario tasks drive byte streams; observed memory writes are
// compared against an expected queue filled when each stream is launched.
module tb_boot_loader;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;
    localparam int SB_W    = ADDR_W + INSTR_W;

    logic               clk;
    logic               Reset;
    logic               load_req;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               cpu_nReset;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] obs_q[$];
    logic [7:0]      good_img[6];

    boot_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .load_req   (load_req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_nReset (cpu_nReset),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every pulse seen between edges.
    always @(negedge clk) begin
        if (!Reset && mem_we) begin
            obs_q.push_back({mem_addr, mem_wdata});
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        Reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (waited >= 50) begin
            tests_failed++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
        end
        @(posedge clk);
    endtask

    task automatic stream_good(input logic [7:0] last, input int gap);
        for (int i = 0; i < 5; i++) send_byte(good_img[i], gap);
        send_byte(last, gap);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_good_writes();
        exp_q.push_back({8'd0, 16'h1234});
        exp_q.push_back({8'd1, 16'hABCD});
    endtask

    // Scoreboard drain (inlined per scenario via this compare of popped entries)
    task automatic test_scoreboard(input string name);
        logic [SB_W-1:0] e;
        logic [SB_W-1:0] o;
        repeat (2) @(negedge clk);
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL %s_write: got addr=%02h data=%04h, required addr=%02h data=%04h",
                         name, o[SB_W-1:INSTR_W], o[INSTR_W-1:0], e[SB_W-1:INSTR_W], e[INSTR_W-1:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        logic [8:0] got;
        do_reset();
        got = {cpu_nReset, in_ready, mem_we, mem_addr == 8'd0, mem_wdata == 16'd0, busy, done, err, dbg_state == 3'd0};
        tests_run++;
        if (got !== 9'b000110001) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required %b", got, 9'b000110001);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (cpu_nReset !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: cpu_nReset=%0b in_ready=%0b required 0/0", i, cpu_nReset, in_ready);
            end
        end
        test_scoreboard("reset");
    endtask

    task automatic test_good_load(input string name, input int gap);
        push_good_writes();
        pulse_load();
        stream_good(8'h42, gap);
        tests_run++;
        if ({cpu_nReset, done, busy, err, in_ready} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL %s_status: got nRst/done/busy/err/rdy=%b required 11000", name,
                     {cpu_nReset, done, busy, err, in_ready});
        end
        test_scoreboard(name);
        tests_run++;
        if (mem_addr !== 8'd2) begin
            tests_failed++;
            $display("FAIL %s_addr_after: got %0d required 2", name, mem_addr);
        end
    endtask

    task automatic test_bad_checksum();
        push_good_writes();
        pulse_load();
        stream_good(8'h43, 0);
        tests_run++;
        if ({cpu_nReset, done, busy, err, in_ready, dbg_state} !== {5'b00010, 3'd5}) begin
            tests_failed++;
            $display("FAIL bad_csum_status: got nRst/done/busy/err/rdy/state=%b required %b",
                     {cpu_nReset, done, busy, err, in_ready, dbg_state}, {5'b00010, 3'd5});
        end
        test_scoreboard("bad_csum");
    endtask

    task automatic test_empty_image();
        pulse_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if ({cpu_nReset, done, busy, err} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL empty_status: got nRst/done/busy/err=%b required 1100", {cpu_nReset, done, busy, err});
        end
        test_scoreboard("empty");
    endtask

    task automatic test_reset_mid_load();
        pulse_load();
        for (int i = 0; i < 3; i++) send_byte(good_img[i], 0);
        #1;
        Reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({cpu_nReset, busy, in_ready, dbg_state} !== {3'b000, 3'd0}) begin
            tests_failed++;
            $display("FAIL midload_reset: got nRst/busy/rdy/state=%b required 000000",
                     {cpu_nReset, busy, in_ready, dbg_state});
        end
        Reset = 1'b0;
        repeat (10) @(negedge clk);
        test_scoreboard("midload_reset");
    endtask

    task automatic test_reload_from_run();
        test_good_load("pre_reload", 0);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        tests_run++;
        if ({cpu_nReset, done, busy, in_ready, mem_addr == 8'd0} !== 5'b00111) begin
            tests_failed++;
            $display("FAIL reload_drop: got nRst/done/busy/rdy/addr0=%b required 00111",
                     {cpu_nReset, done, busy, in_ready, mem_addr == 8'd0});
        end
        push_good_writes();
        stream_good(8'h42, 0);
        tests_run++;
        if ({cpu_nReset, done, err} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reload_status: got nRst/done/err=%b required 110", {cpu_nReset, done, err});
        end
        test_scoreboard("reload");
    endtask

    initial begin
        good_img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        Reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_good_load("good", 0);
        test_bad_checksum();
        test_good_load("gapped", 3);
        test_empty_image();
        test_reset_mid_load();
        test_reload_from_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
